// File: rtl/mdu_sched.sv
// E-stage multiply/divide sequencer: HI/LO owner, busy window and D-stage stall.
// Results are computed at launch and held pending until the busy count expires.
module mdu_sched #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        md,
  input  logic [2:0]  mudeop,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        cancel,
  input  logic        d_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam int MAXC  = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CLOG  = $clog2(MAXC + 1);
  localparam int CNT_W = (CLOG < 4) ? 4 : CLOG;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] phi_q, phi_d;
  logic [31:0] plo_q, plo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        pwr_q, pwr_d;

  logic               div_zero;
  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic signed [32:0] sdvd;
  logic signed [32:0] sdvs;
  logic signed [32:0] squo;
  logic signed [32:0] srem;
  logic [31:0]        udvs;
  logic [31:0]        uquo;
  logic [31:0]        urem;
  logic [31:0]        res_hi;
  logic [31:0]        res_lo;
  logic               launch;
  logic               mv_hi;
  logic               mv_lo;
  logic               unused_sign;

  // 33-bit signed divide keeps 0x80000000 / -1 representable
  always_comb begin
    div_zero = (rt == 32'd0);
    prod_s   = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    prod_u   = {32'd0, rs} * {32'd0, rt};
    sdvd     = $signed({rs[31], rs});
    sdvs     = div_zero ? 33'sd1 : $signed({rt[31], rt});
    squo     = sdvd / sdvs;
    srem     = sdvd % sdvs;
    udvs     = div_zero ? 32'd1 : rt;
    uquo     = rs / udvs;
    urem     = rs % udvs;
    res_hi   = '0;
    res_lo   = '0;
    unique case (mudeop[1:0])
      2'b00: {res_hi, res_lo} = prod_s;
      2'b01: {res_hi, res_lo} = prod_u;
      2'b10: begin
        res_hi = srem[31:0];
        res_lo = squo[31:0];
      end
      default: begin
        res_hi = urem;
        res_lo = uquo;
      end
    endcase
  end

  assign unused_sign = ^{squo[32], srem[32]};

  always_comb begin
    launch = md && !cancel && start && !mudeop[2];
    mv_hi  = md && !cancel && (mudeop == 3'b110);
    mv_lo  = md && !cancel && (mudeop == 3'b111);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    pwr_d   = pwr_q;
    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          launch: begin
            phi_d   = res_hi;
            plo_d   = res_lo;
            pwr_d   = !(mudeop[1] && div_zero);
            cnt_d   = mudeop[1] ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
            state_d = S_BUSY;
          end
          mv_hi:   hi_d = rs;
          mv_lo:   lo_d = rs;
          default: ;
        endcase
      end
      default: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          if (pwr_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pwr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pwr_q   <= pwr_d;
    end
  end

  assign busy     = (state_q == S_BUSY);
  assign md_stall = d_md && (busy || start);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign md_out   = (mudeop == 3'b100) ? hi_q :
                    (mudeop == 3'b101) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu_sched.sv
// Directed bench for mdu_sched: vector table plus hand-written
// cancel, move, reset and back-to-back sequences.
module tb_mdu_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        md;
  logic [2:0]  mudeop;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        cancel;
  logic        d_md;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [31:0] PRE_HI = 32'h1111_1111;
  localparam logic [31:0] PRE_LO = 32'h2222_2222;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  vec_t vt [10];

  always #5 clk = ~clk;

  mdu_sched dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md       (md),
    .mudeop   (mudeop),
    .rs       (rs),
    .rt       (rt),
    .cancel   (cancel),
    .d_md     (d_md),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo),
    .md_out   (md_out)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // an MD op reaching an edge while busy means the stall was ignored
  always @(posedge clk) begin
    if (reset === 1'b1 && busy === 1'b1) begin
      n_chk++;
      if (md === 1'b1 && cancel !== 1'b1) begin
        n_fail++;
        $display("FAIL md_while_busy: got md=%b expected 0", md);
      end
    end
  end

  task automatic idle();
    start  = 1'b0;
    md     = 1'b0;
    cancel = 1'b0;
    d_md   = 1'b0;
    mudeop = 3'b000;
    rs     = '0;
    rt     = '0;
  endtask

  task automatic preload(input logic [31:0] h, input logic [31:0] l);
    md = 1'b1;
    mudeop = 3'b110;
    rs = h;
    @(negedge clk);
    mudeop = 3'b111;
    rs = l;
    @(negedge clk);
    idle();
  endtask

  task automatic launch(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    start  = 1'b1;
    md     = 1'b1;
    mudeop = op;
    rs     = a;
    rt     = b;
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int n;
    n = v.op[1] ? 10 : 5;
    preload(PRE_HI, PRE_LO);
    launch(v.op, v.a, v.b);
    d_md = 1'b1;
    #1;
    chk($sformatf("v%0d launch_stall", k), 32'(md_stall), 32'd1);
    chk($sformatf("v%0d launch_busy", k), 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    md = 1'b0;
    rs = '0;
    rt = '0;
    for (int i = 0; i < n; i++) begin
      #1;
      chk($sformatf("v%0d busy_c%0d", k, i + 1), 32'(busy), 32'd1);
      chk($sformatf("v%0d stall_c%0d", k, i + 1), 32'(md_stall), 32'd1);
      chk($sformatf("v%0d hold_hi_c%0d", k, i + 1), hi, PRE_HI);
      @(negedge clk);
    end
    #1;
    chk($sformatf("v%0d done_busy", k), 32'(busy), 32'd0);
    chk($sformatf("v%0d done_stall", k), 32'(md_stall), 32'd0);
    chk($sformatf("v%0d hi", k), hi, v.eh);
    chk($sformatf("v%0d lo", k), lo, v.el);
    md = 1'b1;
    mudeop = 3'b100;
    #1;
    chk($sformatf("v%0d mfhi", k), md_out, v.eh);
    mudeop = 3'b101;
    #1;
    chk($sformatf("v%0d mflo", k), md_out, v.el);
    idle();
    @(negedge clk);
  endtask

  initial begin
    vt[0] = '{3'b000, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vt[1] = '{3'b001, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA};
    vt[2] = '{3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vt[3] = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000};
    vt[4] = '{3'b010, 32'd5, 32'd0, PRE_HI, PRE_LO};
    vt[5] = '{3'b011, 32'hFFFF_FFF9, 32'd2, 32'h1, 32'h7FFF_FFFC};
    vt[6] = '{3'b011, 32'd9, 32'd0, PRE_HI, PRE_LO};
    vt[7] = '{3'b000, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0};
    vt[8] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1};
    vt[9] = '{3'b010, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD};

    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start  = 1'($urandom);
      md     = 1'($urandom);
      mudeop = 3'($urandom);
      rs     = $urandom;
      rt     = $urandom;
      cancel = 1'($urandom);
      d_md   = 1'($urandom);
      @(negedge clk);
    end
    idle();
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    chk("rst stall", 32'(md_stall), 32'd0);
    chk("rst md_out", md_out, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 10; k++) run_vec(vt[k], k);

    // launch suppressed by cancel
    preload(PRE_HI, PRE_LO);
    launch(3'b000, 32'd6, 32'd7);
    cancel = 1'b1;
    @(negedge clk);
    idle();
    #1;
    chk("cancel_start busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("cancel_start busy2", 32'(busy), 32'd0);
    chk("cancel_start hi", hi, PRE_HI);
    chk("cancel_start lo", lo, PRE_LO);

    // mtlo suppressed by cancel
    md = 1'b1;
    mudeop = 3'b111;
    rs = 32'h1234;
    cancel = 1'b1;
    @(negedge clk);
    idle();
    #1;
    chk("cancel_mtlo lo", lo, PRE_LO);

    // cancel inside the busy window; d_md low keeps stall off
    launch(3'b010, 32'hFFFF_FFF9, 32'd2);
    #1;
    chk("nostall launch", 32'(md_stall), 32'd0);
    @(negedge clk);
    idle();
    for (int i = 0; i < 10; i++) begin
      cancel = (i == 2);
      #1;
      chk($sformatf("nostall c%0d", i + 1), 32'(md_stall), 32'd0);
      @(negedge clk);
    end
    cancel = 1'b0;
    #1;
    chk("cancel_busy busy", 32'(busy), 32'd0);
    chk("cancel_busy hi", hi, 32'hFFFF_FFFF);
    chk("cancel_busy lo", lo, 32'hFFFF_FFFD);

    // mthi then reads
    md = 1'b1;
    mudeop = 3'b110;
    rs = 32'hAAAA_5555;
    @(negedge clk);
    mudeop = 3'b101;
    rs = '0;
    #1;
    chk("mflo after mthi", md_out, 32'hFFFF_FFFD);
    mudeop = 3'b100;
    #1;
    chk("mfhi after mthi", md_out, 32'hAAAA_5555);
    mudeop = 3'b010;
    md = 1'b0;
    #1;
    chk("md_out other", md_out, 32'd0);
    idle();

    // back-to-back: second launch on first idle cycle
    launch(3'b000, 32'hFFFF_FFFE, 32'd3);
    @(negedge clk);
    idle();
    repeat (5) @(negedge clk);
    #1;
    chk("b2b busy_gap", 32'(busy), 32'd0);
    chk("b2b hi1", hi, 32'hFFFF_FFFF);
    launch(3'b001, 32'd5, 32'd7);
    @(negedge clk);
    idle();
    #1;
    chk("b2b busy2", 32'(busy), 32'd1);
    repeat (5) @(negedge clk);
    #1;
    chk("b2b hi2", hi, 32'd0);
    chk("b2b lo2", lo, 32'd35);

    // reset during busy cycle 3 discards the operation
    preload(PRE_HI, PRE_LO);
    launch(3'b000, 32'hFFFF_FFFE, 32'd3);
    @(negedge clk);
    idle();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst hi", hi, 32'd0);
    chk("midrst lo", lo, 32'd0);
    repeat (6) @(negedge clk);
    chk("midrst late hi", hi, 32'd0);
    chk("midrst late lo", lo, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_sched.md
# mdu_sched

Sequencer for the E-stage multiply/divide unit of the pipelined MIPS core. It accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo operations from the D-to-E pipeline register's control outputs (`start`, `md`, `mudeop`). It models the multi-cycle busy window, owns the HI/LO registers, and raises the D-stage stall when a younger MD instruction would collide with an in-flight operation. Exception flush from CP0 suppresses launch of the E-stage operation.

## Interface
- `MULT_CYC`, 5: busy cycles for mult/multu.
- `DIV_CYC`, 10: busy cycles for div/divu.

- `clk`  in  1  core clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset, sampled on `clk` rising edge).
- `start`  in  1  E-stage instruction is mult/multu/div/divu.
- `md`  in  1  E-stage instruction is any MD instruction.
- `mudeop`  in  3  encoding: 000 mult, 001 multu, 010 div, 011 divu, 100 mfhi, 101 mflo, 110 mthi, 111 mtlo.
- `rs`  in  32  forwarded rs operand in E.
- `rt`  in  32  forwarded rt operand in E.
- `cancel`  in  1  exception/interrupt flush; the E-stage instruction must not take effect.
- `d_md`  in  1  D-stage instruction is an MD instruction.
- `busy`  out  1  operation in flight.
- `md_stall`  out  1  stall request to D/F stages.
- `hi`  out  32  architectural HI.
- `lo`  out  32  architectural LO.
- `md_out`  out  32  mfhi/mflo read data.

## Operation
- States: IDLE, BUSY. A down-counter `cnt` (4 bits minimum) is active only in BUSY.
- Launch: in IDLE, `start`=1, `md`=1, `cancel`=0 at an edge → compute the result from `rs`/`rt` into pending `phi`/`plo`, load `cnt` with `MULT_CYC` (mudeop 00x) or `DIV_CYC` (01x), and go to BUSY.
- BUSY: decrement `cnt` each edge. On the edge where `cnt`==1, write `phi`/`plo` into `hi`/`lo` and return to IDLE.
- mult: {hi,lo} = $signed(rs)*$signed(rt), 64-bit. multu: unsigned 64-bit product.
- div: lo = signed quotient truncated toward zero; hi = remainder with the dividend's sign. 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned quotient/remainder.
- Divide by zero: still consumes `DIV_CYC` cycles; `hi`/`lo` unchanged at commit.
- mthi/mtlo: `md`=1, `mudeop`=110/111, `cancel`=0, state IDLE → `hi` or `lo` ← `rs` at that edge. This is a single-cycle operation and never enters BUSY.
- mfhi/mflo: `md_out` = `hi` when `mudeop`=100, `lo` when `mudeop`=101, else 0. This output is combinational and does not depend on state.
- `md_stall` = `d_md` & (`busy` | `start`). This is combinational.
- Operations arriving while BUSY (`start` or mthi/mtlo) are ignored. Correct stalling makes this unreachable; the bench asserts it never occurs.
- `cancel` during BUSY does not abort the in-flight operation, because that operation is older than the excepting instruction. It does block any launch or move in that cycle.
- `start`=1 with `md`=0 is treated as no operation.

## Timing
- Reset: `busy`=0, `hi`=0, `lo`=0, state IDLE, `cnt`=0, `phi`/`plo`=0. `md_stall` and `md_out` follow from these values.
- Reset mid-operation: the BUSY operation is discarded; `hi`/`lo` are cleared, with no commit.
- Launch edge T: `busy` is high for the cycles after T through T+N and drops after edge T+N, where N = `MULT_CYC` or `DIV_CYC`.
- Commit: `hi`/`lo` take the new values at edge T+N and are visible in the cycle after it.
- Back-to-back: a new `start` is accepted at edge T+N+1 at the earliest. It is not accepted at T+N, because the state is still BUSY at that edge.
- mthi/mtlo: the write is visible in the cycle after its edge.
- `md_stall` is asserted in the launch cycle itself (`start`=1) and through every BUSY cycle.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with random inputs → `busy`=0, `hi`=`lo`=0, `md_stall`=0.
- mult: `rs`=0xFFFFFFFE (−2), `rt`=3, `mudeop`=000 → `busy` high for 5 cycles, then `hi`=0xFFFFFFFF and `lo`=0xFFFFFFFA. Under multu the same operands give `hi`=0x00000002, `lo`=0xFFFFFFFA.
- div: `rs`=0xFFFFFFF9 (−7), `rt`=2 → after 10 busy cycles `lo`=0xFFFFFFFD and `hi`=0xFFFFFFFF. Overflow case 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0. Divide by zero leaves `hi`/`lo` unchanged.
- Stall: div launched with `d_md`=1 held → `md_stall`=1 in the launch cycle and all 10 BUSY cycles, and 0 the cycle after commit. The same sequence with `d_md`=0 gives `md_stall`=0 throughout.
- Cancel: `start`=1 with `cancel`=1 → `busy` stays 0 and `hi`/`lo` unchanged. mtlo `rs`=0x1234 with `cancel`=1 leaves `lo` unchanged. `cancel` pulsed during BUSY still yields a correct commit.
- Moves and reads: mthi 0xAAAA5555 then mflo/mfhi → `md_out`=`lo` and 0xAAAA5555 respectively. `reset`=0 at BUSY cycle 3 of a mult → no commit and `hi`=`lo`=0.
